// File: rtl/twin_reg_arbiter_if.sv
// Request/grant/data bundle between the two producers and the twin-register arbiter.
interface twin_reg_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             req_a;
    logic [1:0]       op_a;
    logic [WIDTH-1:0] d_a;
    logic             req_b;
    logic [1:0]       op_b;
    logic [WIDTH-1:0] d_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             done_a;
    logic             done_b;
    logic             busy;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [CNT_W-1:0] ops_cnt;

    modport master (
        output req_a, op_a, d_a, req_b, op_b, d_b,
        input  gnt_a, gnt_b, done_a, done_b, busy, q1, q2, ops_cnt
    );

    modport slave (
        input  req_a, op_a, d_a, req_b, op_b, d_b,
        output gnt_a, gnt_b, done_a, done_b, busy, q1, q2, ops_cnt
    );
endinterface

// File: rtl/twin_reg_arbiter.sv
// Round-robin arbiter giving requesters A and B exclusive write access to q1/q2.
module twin_reg_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    twin_reg_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;

    state_t           state, state_nxt;
    logic             ptr_b;
    logic             win_b;
    logic             pick_b;
    logic [1:0]       hold_op;
    logic [WIDTH-1:0] hold_d;
    logic [WIDTH-1:0] q1_r, q2_r;
    logic [CNT_W-1:0] cnt_r;

    // B wins only if A is absent or the pointer currently favours B
    assign pick_b = bus.req_b && (!bus.req_a || ptr_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_a || bus.req_b) state_nxt = GRANT;
            GRANT:   state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_b   <= 1'b0;
            win_b   <= 1'b0;
            hold_op <= '0;
            hold_d  <= '0;
            q1_r    <= '0;
            q2_r    <= '0;
            cnt_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_a || bus.req_b) begin
                        win_b   <= pick_b;
                        hold_op <= pick_b ? bus.op_b : bus.op_a;
                        hold_d  <= pick_b ? bus.d_b : bus.d_a;
                    end
                end
                GRANT: begin
                    case (hold_op)
                        2'b00: q1_r <= hold_d;
                        2'b01: q2_r <= hold_d;
                        2'b10: begin
                            q1_r <= hold_d;
                            q2_r <= hold_d;
                        end
                        default: begin
                            q1_r <= '1;
                            q2_r <= '1;
                        end
                    endcase
                    cnt_r <= cnt_r + CNT_W'(1);
                    ptr_b <= ~win_b;
                end
                default: ;
            endcase
        end
    end

    // gnt/done decode purely from registered state and winner, so they are glitch-free
    always_comb begin
        bus.gnt_a  = 1'b0;
        bus.gnt_b  = 1'b0;
        bus.done_a = 1'b0;
        bus.done_b = 1'b0;
        bus.busy   = (state != IDLE);
        if (state == GRANT) begin
            bus.gnt_a = ~win_b;
            bus.gnt_b = win_b;
        end
        if (state == COMMIT) begin
            bus.done_a = ~win_b;
            bus.done_b = win_b;
        end
    end

    assign bus.q1      = q1_r;
    assign bus.q2      = q2_r;
    assign bus.ops_cnt = cnt_r;
endmodule

// File: tb/tb_twin_reg_arbiter.sv
// Self-checking bench for twin_reg_arbiter against a transaction-level reference model.
module tb_twin_reg_arbiter;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    twin_reg_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
    twin_reg_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [7:0] m_q1, m_q2, m_cnt;
    bit         m_ptr_b;

    function automatic void model_reset();
        m_q1 = 8'h00; m_q2 = 8'h00; m_cnt = 8'h00; m_ptr_b = 1'b0;
    endfunction

    function automatic bit model_pick_b(bit ra, bit rb);
        return rb && (!ra || m_ptr_b);
    endfunction

    function automatic void model_commit(bit who_b, logic [1:0] op, logic [7:0] d);
        case (op)
            2'b00: m_q1 = d;
            2'b01: m_q2 = d;
            2'b10: begin m_q1 = d; m_q2 = d; end
            default: begin m_q1 = 8'hFF; m_q2 = 8'hFF; end
        endcase
        m_cnt   = m_cnt + 8'd1;
        m_ptr_b = !who_b;
    endfunction

    task automatic wait_gnt(output bit ga, output bit gb, output int n);
        ga = 0; gb = 0; n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n++;
            if (bus.gnt_a || bus.gnt_b) begin
                ga = bus.gnt_a; gb = bus.gnt_b;
                return;
            end
        end
    endtask

    task automatic wait_done(output bit da, output bit db, output int n);
        da = 0; db = 0; n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n++;
            if (bus.done_a || bus.done_b) begin
                da = bus.done_a; db = bus.done_b;
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_a = 0; bus.op_a = '0; bus.d_a = '0;
        bus.req_b = 0; bus.op_b = '0; bus.d_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_a = 0; bus.op_a = '0; bus.d_a = '0;
        bus.req_b = 0; bus.op_b = '0; bus.d_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if ({bus.busy, bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000", {bus.busy, bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b});
        end
        total++;
        if (bus.q1 !== 8'h00) begin bad++; $display("FAIL reset_q1 got=%h exp=00", bus.q1); end
        total++;
        if (bus.q2 !== 8'h00) begin bad++; $display("FAIL reset_q2 got=%h exp=00", bus.q2); end
        total++;
        if (bus.ops_cnt !== 8'h00) begin bad++; $display("FAIL reset_cnt got=%h exp=00", bus.ops_cnt); end
    endtask

    task automatic test_single();
        bit ga, gb, da, db;
        int n;
        bus.req_a = 1; bus.op_a = 2'b00; bus.d_a = 8'hAA;
        wait_gnt(ga, gb, n);
        total++;
        if ({ga, gb} !== 2'b10) begin bad++; $display("FAIL single_gnt got=%b exp=10", {ga, gb}); end
        total++;
        if (bus.q1 !== 8'h00 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL single_grant_cycle q1=%h busy=%b exp q1=00 busy=1", bus.q1, bus.busy);
        end
        model_commit(0, 2'b00, 8'hAA);
        wait_done(da, db, n);
        bus.req_a = 0;
        total++;
        if ({da, db, n} !== {2'b10, 32'd1}) begin bad++; $display("FAIL single_done got=%b n=%0d exp=10 n=1", {da, db}, n); end
        total++;
        if ({bus.q1, bus.q2, bus.ops_cnt} !== {8'hAA, 8'h00, 8'h01}) begin
            bad++; $display("FAIL single_regs got q1=%h q2=%h cnt=%h exp AA 00 01", bus.q1, bus.q2, bus.ops_cnt);
        end
    endtask

    task automatic test_contention();
        bit ga, gb, da, db, eb;
        int n;
        do_reset();
        bus.req_a = 1; bus.op_a = 2'b01; bus.d_a = 8'h3C;
        bus.req_b = 1; bus.op_b = 2'b00; bus.d_b = 8'hC3;
        for (int k = 0; k < 4; k++) begin
            eb = model_pick_b(1, 1);
            wait_gnt(ga, gb, n);
            total++;
            if ({ga, gb} !== {!eb, eb} || eb !== k[0]) begin
                bad++; $display("FAIL cont_gnt%0d got=%b exp=%b", k, {ga, gb}, {!eb, eb});
            end
            total++;
            if ((k > 0 && n != 2) || bus.done_a || bus.done_b) begin
                bad++; $display("FAIL cont_cadence%0d gap=%0d done=%b%b exp gap=2 done=00", k, n, bus.done_a, bus.done_b);
            end
            model_commit(eb, eb ? bus.op_b : bus.op_a, eb ? bus.d_b : bus.d_a);
            wait_done(da, db, n);
            total++;
            if ({da, db} !== {!eb, eb} || bus.gnt_a || bus.gnt_b) begin
                bad++; $display("FAIL cont_done%0d got=%b gnt=%b%b exp=%b", k, {da, db}, bus.gnt_a, bus.gnt_b, {!eb, eb});
            end
            total++;
            if ({bus.q1, bus.q2, bus.ops_cnt} !== {m_q1, m_q2, m_cnt}) begin
                bad++; $display("FAIL cont_regs%0d got %h %h %h exp %h %h %h", k, bus.q1, bus.q2, bus.ops_cnt, m_q1, m_q2, m_cnt);
            end
            if (k == 1) begin
                total++;
                if ({bus.q1, bus.q2} !== {8'hC3, 8'h3C}) begin
                    bad++; $display("FAIL cont_pair got q1=%h q2=%h exp C3 3C", bus.q1, bus.q2);
                end
            end
        end
        bus.req_a = 0; bus.req_b = 0;
    endtask

    task automatic test_loadboth_setall();
        bit ga, gb, da, db;
        int n;
        bus.req_b = 1; bus.op_b = 2'b10; bus.d_b = 8'h5A;
        wait_gnt(ga, gb, n);
        total++;
        if ({ga, gb} !== 2'b01) begin bad++; $display("FAIL loadboth_gnt got=%b exp=01", {ga, gb}); end
        model_commit(1, 2'b10, 8'h5A);
        wait_done(da, db, n);
        bus.req_b = 0;
        total++;
        if ({da, db, bus.q1, bus.q2} !== {2'b01, 8'h5A, 8'h5A}) begin
            bad++; $display("FAIL loadboth got done=%b q1=%h q2=%h exp 01 5A 5A", {da, db}, bus.q1, bus.q2);
        end
        bus.req_a = 1; bus.op_a = 2'b11; bus.d_a = 8'h00;
        wait_gnt(ga, gb, n);
        model_commit(0, 2'b11, 8'h00);
        wait_done(da, db, n);
        bus.req_a = 0;
        total++;
        if ({da, db, bus.q1, bus.q2, bus.ops_cnt} !== {2'b10, 8'hFF, 8'hFF, m_cnt}) begin
            bad++; $display("FAIL setall got done=%b q1=%h q2=%h cnt=%h exp 10 FF FF %h", {da, db}, bus.q1, bus.q2, bus.ops_cnt, m_cnt);
        end
    endtask

    task automatic test_data_change();
        bit ga, gb, da, db;
        int n;
        bus.req_a = 1; bus.op_a = 2'b00; bus.d_a = 8'h11;
        wait_gnt(ga, gb, n);
        bus.op_a = 2'b11; bus.d_a = 8'h99;
        model_commit(0, 2'b00, 8'h11);
        wait_done(da, db, n);
        bus.req_a = 0;
        total++;
        if ({da, bus.q1, bus.q2} !== {1'b1, m_q1, m_q2} || m_q1 !== 8'h11) begin
            bad++; $display("FAIL data_change got done=%b q1=%h q2=%h exp 1 11 %h", da, bus.q1, bus.q2, m_q2);
        end
    endtask

    task automatic test_async_reset();
        bit ga, gb, da, db, seen;
        int n;
        do_reset();
        bus.req_a = 1; bus.op_a = 2'b01; bus.d_a = 8'h77;
        wait_gnt(ga, gb, n);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.gnt_a, bus.q2} !== {2'b00, 8'h00}) begin
            bad++; $display("FAIL async_rst got busy=%b gnt_a=%b q2=%h exp 0 0 00", bus.busy, bus.gnt_a, bus.q2);
        end
        bus.req_a = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done_a || bus.done_b || bus.busy || bus.q2 !== 8'h00) seen = 1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL async_no_commit got activity=%b exp=0", seen); end
        bus.req_a = 1; bus.op_a = 2'b00; bus.d_a = 8'h21;
        bus.req_b = 1; bus.op_b = 2'b01; bus.d_b = 8'h42;
        wait_gnt(ga, gb, n);
        total++;
        if ({ga, gb} !== 2'b10) begin bad++; $display("FAIL async_ptr got=%b exp=10", {ga, gb}); end
        model_commit(0, 2'b00, 8'h21);
        wait_done(da, db, n);
        bus.req_a = 0; bus.req_b = 0;
    endtask

    task automatic test_random();
        bit ga, gb, da, db, eb;
        int n;
        bus.req_a = 0; bus.req_b = 0;
        for (int k = 0; k < 40; k++) begin
            if (!bus.req_a && !bus.req_b) begin
                if ($urandom_range(1, 0) == 0) bus.req_a = 1; else bus.req_b = 1;
                if ($urandom_range(1, 0) == 0) begin bus.req_a = 1; bus.req_b = 1; end
            end
            eb = model_pick_b(bus.req_a, bus.req_b);
            wait_gnt(ga, gb, n);
            total++;
            if ({ga, gb} !== {!eb, eb}) begin bad++; $display("FAIL rand_gnt%0d got=%b exp=%b", k, {ga, gb}, {!eb, eb}); end
            model_commit(eb, eb ? bus.op_b : bus.op_a, eb ? bus.d_b : bus.d_a);
            if (eb) begin bus.op_b = 2'($urandom); bus.d_b = 8'($urandom); end
            else    begin bus.op_a = 2'($urandom); bus.d_a = 8'($urandom); end
            wait_done(da, db, n);
            total++;
            if ({da, db, bus.q1, bus.q2, bus.ops_cnt} !== {!eb, eb, m_q1, m_q2, m_cnt}) begin
                bad++; $display("FAIL rand_commit%0d got done=%b %h %h %h exp %b %h %h %h", k, {da, db},
                                bus.q1, bus.q2, bus.ops_cnt, {!eb, eb}, m_q1, m_q2, m_cnt);
            end
            if (eb) begin
                bus.req_b = 1'($urandom);
                if (!bus.req_a && $urandom_range(1, 0) == 1) begin
                    bus.req_a = 1; bus.op_a = 2'($urandom); bus.d_a = 8'($urandom);
                end
            end else begin
                bus.req_a = 1'($urandom);
                if (!bus.req_b && $urandom_range(1, 0) == 1) begin
                    bus.req_b = 1; bus.op_b = 2'($urandom); bus.d_b = 8'($urandom);
                end
            end
        end
        bus.req_a = 0; bus.req_b = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wrap();
        bit ga, gb, da, db;
        int n, errs;
        logic [7:0] last;
        do_reset();
        errs = 0;
        last = 8'h00;
        bus.req_a = 1; bus.op_a = 2'b00;
        for (int i = 0; i < 256; i++) begin
            last = 8'($urandom);
            bus.d_a = last;
            wait_gnt(ga, gb, n);
            if ({ga, gb} !== 2'b10 || (i > 0 && n != 2)) errs++;
            model_commit(0, 2'b00, last);
            wait_done(da, db, n);
            if (da !== 1'b1 || bus.q1 !== last || bus.ops_cnt !== m_cnt) errs++;
            if (i == 254) begin
                total++;
                if (bus.ops_cnt !== 8'hFF) begin bad++; $display("FAIL wrap_pre got=%h exp=FF", bus.ops_cnt); end
            end
        end
        bus.req_a = 0;
        total++;
        if (errs != 0) begin bad++; $display("FAIL wrap_seq got errors=%0d exp=0", errs); end
        total++;
        if ({bus.ops_cnt, bus.q1} !== {8'h00, last}) begin
            bad++; $display("FAIL wrap_end got cnt=%h q1=%h exp 00 %h", bus.ops_cnt, bus.q1, last);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_loadboth_setall();
        test_data_change();
        test_async_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/twin_reg_arbiter.md
Name: twin_reg_arbiter

Overview:
- Shares one pair of WIDTH-bit data registers (q1, q2) between two independent requesters, A and B.
- Arbitrates round-robin, captures the winner's opcode and data, commits it to the register pair, then signals completion.
- Sits between two producer blocks and the twin-register storage. It is the only writer of q1/q2.

Parameters:
- WIDTH, 8, data width of d_a, d_b, q1, q2.
- CNT_W, 8, width of the committed-operation counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A operation request; level, held until done_a.
- op_a  in  2  A opcode: 00 LOAD1, 01 LOAD2, 10 LOADBOTH, 11 SETALL.
- d_a  in  WIDTH  A data.
- req_b  in  1  requester B request, same rules as A.
- op_b  in  2  B opcode.
- d_b  in  WIDTH  B data.
- gnt_a  out  1  one-cycle pulse: A won arbitration and its op/data were captured.
- gnt_b  out  1  one-cycle pulse for B.
- done_a  out  1  one-cycle pulse: A's operation is committed to q1/q2.
- done_b  out  1  one-cycle pulse for B.
- busy  out  1  high whenever state is not IDLE.
- q1  out  WIDTH  register 1.
- q2  out  WIDTH  register 2.
- ops_cnt  out  CNT_W  count of committed operations; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; priority pointer selects A.
  - q1, q2, ops_cnt = 0; gnt_*, done_*, busy = 0.
  - Takes effect immediately, including mid-operation; any captured operation is discarded with no commit and no done pulse.
- State machine (registered state and outputs): IDLE -> GRANT -> COMMIT -> IDLE.
- IDLE:
  - Arbitration is evaluated only in this state, on the rising edge.
  - Only one requester high: it wins.
  - Both high: the requester the pointer selects wins.
  - Winner's op and d are latched into holding registers. Next state is GRANT; gnt_<winner>=1 for the GRANT cycle.
  - No request: remain in IDLE.
- GRANT:
  - On the next edge, the held op is applied and the state moves to COMMIT.
  - LOAD1: q1<=d; q2 holds.
  - LOAD2: q2<=d; q1 holds.
  - LOADBOTH: q1<=d and q2<=d.
  - SETALL: q1 and q2 all ones; d is ignored.
  - On the same edge: ops_cnt increments and the pointer moves to the non-winner.
- COMMIT:
  - done_<winner>=1 for this cycle only.
  - Unconditional move to IDLE on the next edge; no arbitration on that edge.
- Latency: req sampled at edge N; gnt during cycle N..N+1; q1/q2 update at edge N+1; done during N+1..N+2; earliest next arbitration at edge N+3. Peak throughput is one operation per 3 cycles.
- Requester rules:
  - Deassert req on the edge done is sampled, or keep it high to request again.
  - A requester whose req is still high in IDLE is treated as a new request.
  - Changes to op/d after gnt have no effect, because the values were captured.
  - Dropping req after gnt does not cancel the operation; it still commits and done still pulses.
- Mutual exclusion: gnt_a and gnt_b are never both high, and the same holds for done_a/done_b. busy=0 exactly when state is IDLE.
- Fairness: under continuous requests from both, grants alternate A,B,A,B starting with A after reset.
- ops_cnt wraps from all ones to 0 with no flag.

Test Plan:
- Reset then single op: rst high 2 cycles, then low; req_a=1, op_a=00, d_a=8'hAA → gnt_a 1 cycle later; q1=8'hAA and q2=8'h00 one edge after that; done_a the following cycle; ops_cnt=1.
- Contention: req_a and req_b raised together and held (A: 01/8'h3C, B: 00/8'hC3) → grants in order A,B,A,B. After the first A+B pair, q2=8'h3C and q1=8'hC3; no gnt or done overlap.
- LOADBOTH/SETALL: B op 10 d=8'h5A → q1=q2=8'h5A. Then A op 11 d=8'h00 → q1=q2=8'hFF.
- Data change after grant: A LOAD1 d=8'h11; change d_a to 8'h99 during the GRANT cycle → q1=8'h11.
- Async reset mid-op: assert rst between clock edges during GRANT of LOAD2 d=8'h77 → q2 stays 8'h00, no done, busy=0 immediately. After release, the pointer selects A.
- Counter wrap: 256 back-to-back A LOAD1 ops → ops_cnt reads 0 after the 256th commit, with q1 equal to the last data written.
